maf_wallace_arb: RTL and testbench
==================================

# maf_wallace_arb

Round-robin arbiter that shares one 6-row-to-2-row Wallace reduction slice (48-bit, L4→L5) between two MAF requester lanes. It accepts six 48-bit partial-product rows per transaction from either lane and reduces them through the combinational slice. Each result goes into a 2-entry output buffer, and the block returns a carry/sum pair tagged with source lane and requester tag. It sits between the lane partial-product generators and the shared final-adder stage.

## Interface
- `WIDTH`, default 48: row, sum and carry width.
- `TAGW`, default 4: requester tag width.
- `clk` input, 1: clock; all state updates on the rising edge.
- `rst` input, 1: asynchronous active-high reset.
- `req0_valid` input, 1: lane 0 has a transaction.
- `req0_ready` output, 1: lane 0 transaction accepted this cycle.
- `req0_rows` input, 6*WIDTH: six rows; row k occupies bits [k*WIDTH +: WIDTH].
- `req0_tag` input, TAGW: lane 0 tag.
- `req1_valid`, `req1_ready`, `req1_rows`, `req1_tag`: same as lane 0, for lane 1.
- `rsp_valid` output, 1: result available.
- `rsp_ready` input, 1: consumer takes the result.
- `rsp_src` output, 1: lane that issued the result.
- `rsp_tag` output, TAGW: tag of the result.
- `rsp_sum` output, WIDTH: reduced sum vector.
- `rsp_carry` output, WIDTH: reduced carry vector, weight-aligned so that `rsp_sum + rsp_carry` equals the sum of the six rows mod 2^WIDTH.

## Operation
- Arbitration state: `last_grant`, 1 bit.
  - Round-robin: when both lanes are valid, grant the lane ≠ `last_grant`. When one lane is valid, grant that lane.
  - `last_grant` updates only on an accepted transfer.
- Accept condition: `reqX_ready = grant==X && count<2`.
  - Ready may depend on valid; valid must not depend on ready.
  - A lane that is not granted sees ready=0.
  - Requesters hold valid, rows and tag stable until accepted.
- Datapath on accept:
  - The granted lane's rows pass through the combinational 6:2 reduction.
  - `{src, tag, sum, carry}` is written into buffer entry `wr_ptr`.
- Output buffer: 2 entries, `wr_ptr`/`rd_ptr` (1 bit each), `count` 0..2.
  - `rsp_*` presents entry `rd_ptr`; `rsp_valid = count!=0`.
  - Pop when `rsp_valid && rsp_ready`.
- Buffer boundaries:
  - Push and pop in the same cycle: `count` is unchanged and both pointers advance.
  - `count==2`: no accept, even if a pop happens that cycle. There is no combinational ready path from `rsp_ready`.
  - `count==0`: `rsp_ready` is ignored.
  - Pointers wrap modulo 2.
- Results leave in acceptance order, regardless of lane.

## Timing
- Reset values: `last_grant=1` (so lane 0 wins the first contention), `count=0`, `wr_ptr=rd_ptr=0`, `rsp_valid=0`, `rsp_src=0`, `rsp_tag=0`, `rsp_sum=0`, `rsp_carry=0`. Buffer contents are cleared to 0.
- Latency: a transaction accepted in cycle N with an empty buffer gives `rsp_valid=1` in cycle N+1.
- Throughput: 1 transaction per cycle when `rsp_ready` is held high (steady state `count=1`).
- Under stall: a maximum of 2 outstanding results, then `reqX_ready=0` until a pop.
- Reset asserted mid-operation: the buffer empties immediately (asynchronously), `rsp_valid` drops the same instant, and in-flight results are discarded.
- Deassertion: the first accept is possible on the first rising edge after `rst` falls.

## Configuration
- `MAF_ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority, lane 0 always wins contention; `last_grant` is not implemented.
  - Undefined (default): round-robin as described above.
- Buffer, handshake and datapath behaviour are identical in both builds.

## Test plan
- Single lane 0 transaction, rows {1,2,3,4,5,6}, tag 3, `rsp_ready=1` → one cycle later `rsp_valid=1`, `rsp_src=0`, `rsp_tag=3`, `rsp_sum+rsp_carry=21`.
- Both lanes valid continuously, `rsp_ready=1`, round-robin build → accepted source order 0,1,0,1…; 8 results in 8 consecutive cycles. Fixed-priority build → all 8 from lane 0, lane 1 starved.
- `rsp_ready=0`, lane 1 issues 3 transactions → first two accepted, `req1_ready=0` on the third. Raising `rsp_ready` returns tags in order; the third is accepted the cycle after the first pop.
- All rows 0xFFFFFFFFFFFF → `rsp_sum+rsp_carry` mod 2^48 = 0xFFFFFFFFFFFA.
- Assert `rst` with `count=2` → `rsp_valid=0` and both `reqX_ready` low immediately; after release, `count=0` and the next lane-0 tag is the first result out.
- Random rows and tags, random valid/`rsp_ready` for 10k cycles → no loss or duplication, order preserved, arithmetic invariant holds on every result.

Source files
------------

// File: rtl/maf_wallace_arb.sv
// Two-lane arbiter around a shared 6:2 Wallace carry-save slice, with a 2-entry result buffer.
// Define MAF_ARB_FIXED_PRIO_EN for fixed lane-0 priority; the default build is round-robin.
module maf_wallace_arb #(
  parameter int WIDTH = 48,
  parameter int TAGW  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [6*WIDTH-1:0]   req0_rows,
  input  logic [TAGW-1:0]      req0_tag,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [6*WIDTH-1:0]   req1_rows,
  input  logic [TAGW-1:0]      req1_tag,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_src,
  output logic [TAGW-1:0]      rsp_tag,
  output logic [WIDTH-1:0]     rsp_sum,
  output logic [WIDTH-1:0]     rsp_carry
);

  logic       grant;
  logic       space;
  logic       push;
  logic       pop;
  logic [1:0] count_q, count_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;

  // ---------------------------------------------------------------- arbitration
`ifdef MAF_ARB_FIXED_PRIO_EN
  always_comb begin
    grant = 1'b0;
    if (!req0_valid) begin
      grant = req1_valid;
    end
  end
`else
  logic last_grant_q, last_grant_d;

  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant_q;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (push) begin
      last_grant_d = grant;
    end
  end

  // Resets to lane 1 so lane 0 wins the first contention.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  // Ready never looks at rsp_ready, so a full buffer blocks even while popping.
  assign space      = (count_q != 2'd2) && !rst;
  assign req0_ready = space && req0_valid && !grant;
  assign req1_ready = space && req1_valid && grant;
  assign push       = req0_ready || req1_ready;
  assign pop        = (count_q != 2'd0) && rsp_ready;

  // ---------------------------------------------------------------- 6:2 reduction
  logic [6*WIDTH-1:0] sel_rows;
  logic [TAGW-1:0]    sel_tag;
  logic [WIDTH-1:0]   row [6];
  logic [WIDTH-1:0]   s1a, c1a, s1b, c1b;
  logic [WIDTH-1:0]   s2, c2, s3, c3;
  logic [WIDTH-1:0]   c1a_sh, c1b_sh, c2_sh, c3_sh;

  assign sel_rows = grant ? req1_rows : req0_rows;
  assign sel_tag  = grant ? req1_tag  : req0_tag;

  for (genvar gk = 0; gk < 6; gk++) begin : gen_row
    assign row[gk] = sel_rows[gk*WIDTH +: WIDTH];
  end

  // Level 1: two independent 3:2 compressors over rows 0-2 and 3-5.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : gen_l1
    assign s1a[gi] = row[0][gi] ^ row[1][gi] ^ row[2][gi];
    assign c1a[gi] = (row[0][gi] & row[1][gi]) | (row[0][gi] & row[2][gi]) |
                     (row[1][gi] & row[2][gi]);
    assign s1b[gi] = row[3][gi] ^ row[4][gi] ^ row[5][gi];
    assign c1b[gi] = (row[3][gi] & row[4][gi]) | (row[3][gi] & row[5][gi]) |
                     (row[4][gi] & row[5][gi]);
  end

  assign c1a_sh = {c1a[WIDTH-2:0], 1'b0};
  assign c1b_sh = {c1b[WIDTH-2:0], 1'b0};

  for (genvar gi = 0; gi < WIDTH; gi++) begin : gen_l2
    assign s2[gi] = s1a[gi] ^ c1a_sh[gi] ^ s1b[gi];
    assign c2[gi] = (s1a[gi] & c1a_sh[gi]) | (s1a[gi] & s1b[gi]) |
                    (c1a_sh[gi] & s1b[gi]);
  end

  assign c2_sh = {c2[WIDTH-2:0], 1'b0};

  for (genvar gi = 0; gi < WIDTH; gi++) begin : gen_l3
    assign s3[gi] = s2[gi] ^ c2_sh[gi] ^ c1b_sh[gi];
    assign c3[gi] = (s2[gi] & c2_sh[gi]) | (s2[gi] & c1b_sh[gi]) |
                    (c2_sh[gi] & c1b_sh[gi]);
  end

  // Carry leaves already shifted to its true weight.
  assign c3_sh = {c3[WIDTH-2:0], 1'b0};

  // ---------------------------------------------------------------- result buffer
  logic [1:0]             ent_src;
  logic [1:0][TAGW-1:0]   ent_tag;
  logic [1:0][WIDTH-1:0]  ent_sum;
  logic [1:0][WIDTH-1:0]  ent_carry;

  for (genvar gi = 0; gi < 2; gi++) begin : gen_entry
    logic             src_q, src_d;
    logic [TAGW-1:0]  tag_q, tag_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [WIDTH-1:0] carry_q, carry_d;

    always_comb begin
      src_d   = src_q;
      tag_d   = tag_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      if (push && (wr_ptr_q == 1'(gi))) begin
        src_d   = grant;
        tag_d   = sel_tag;
        sum_d   = s3;
        carry_d = c3_sh;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        src_q   <= 1'b0;
        tag_q   <= '0;
        sum_q   <= '0;
        carry_q <= '0;
      end else begin
        src_q   <= src_d;
        tag_q   <= tag_d;
        sum_q   <= sum_d;
        carry_q <= carry_d;
      end
    end

    assign ent_src[gi]   = src_q;
    assign ent_tag[gi]   = tag_q;
    assign ent_sum[gi]   = sum_q;
    assign ent_carry[gi] = carry_q;
  end

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  assign rsp_valid = (count_q != 2'd0);
  assign rsp_src   = ent_src[rd_ptr_q];
  assign rsp_tag   = ent_tag[rd_ptr_q];
  assign rsp_sum   = ent_sum[rd_ptr_q];
  assign rsp_carry = ent_carry[rd_ptr_q];

endmodule

// File: tb/tb_maf_wallace_arb.sv
// Bench for maf_wallace_arb: directed literal cases plus randomized traffic against a queue model.
module tb_maf_wallace_arb;
  localparam int W  = 48;
  localparam int TW = 4;
`ifdef MAF_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            req0_valid = 1'b0, req1_valid = 1'b0;
  logic            req0_ready, req1_ready;
  logic [6*W-1:0]  req0_rows = '0, req1_rows = '0;
  logic [TW-1:0]   req0_tag = '0, req1_tag = '0;
  logic            rsp_valid, rsp_src;
  logic            rsp_ready = 1'b0;
  logic [TW-1:0]   rsp_tag;
  logic [W-1:0]    rsp_sum, rsp_carry;

  maf_wallace_arb #(.WIDTH(W), .TAGW(TW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_rows(req0_rows), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_rows(req1_rows), .req1_tag(req1_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_src(rsp_src), .rsp_tag(rsp_tag),
    .rsp_sum(rsp_sum), .rsp_carry(rsp_carry)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          src;
    logic [TW-1:0] tag;
    logic [W-1:0]  total;
  } exp_t;

  exp_t exp_q[$];
  logic m_last = 1'b1;
  logic m_acc0 = 1'b0, m_acc1 = 1'b0;
  int   n_checks = 0, n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [W-1:0] row_total(input logic [6*W-1:0] rows);
    logic [W-1:0] s;
    s = '0;
    for (int k = 0; k < 6; k++) s = s + rows[k*W +: W];
    return s;
  endfunction

  function automatic logic [6*W-1:0] rand_rows();
    logic [6*W-1:0] r;
    for (int k = 0; k < 6; k++) begin
      if ($urandom_range(7) == 0) r[k*W +: W] = '1;
      else r[k*W +: W] = W'({$urandom, $urandom});
    end
    return r;
  endfunction

  // Reference model: sampled on the falling edge, mirrors what the next rising edge does.
  always @(negedge clk) begin
    logic         g, e0, e1;
    logic [W-1:0] got_total;
    exp_t         e;
    if (rst) begin
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst_req0_ready", 64'(req0_ready), 64'd0);
      check("rst_req1_ready", 64'(req1_ready), 64'd0);
      exp_q.delete();
      m_last = 1'b1;
      m_acc0 = 1'b0;
      m_acc1 = 1'b0;
    end else begin
      if (req0_valid && req1_valid) g = FIXED ? 1'b0 : ~m_last;
      else if (req0_valid)          g = 1'b0;
      else                          g = 1'b1;
      e0 = req0_valid && (g == 1'b0) && (exp_q.size() < 2);
      e1 = req1_valid && (g == 1'b1) && (exp_q.size() < 2);
      check("req0_ready", 64'(req0_ready), 64'(e0));
      check("req1_ready", 64'(req1_ready), 64'(e1));
      check("rsp_valid", 64'(rsp_valid), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        got_total = rsp_sum + rsp_carry;
        check("rsp_src", 64'(rsp_src), 64'(exp_q[0].src));
        check("rsp_tag", 64'(rsp_tag), 64'(exp_q[0].tag));
        check("rsp_sum_plus_carry", 64'(got_total), 64'(exp_q[0].total));
        if (rsp_ready) begin
          $display("rsp src=%0d tag=%0d total=0x%012h", rsp_src, rsp_tag, got_total);
          void'(exp_q.pop_front());
        end
      end
      if (e0 || e1) begin
        e.src   = g;
        e.tag   = g ? req1_tag : req0_tag;
        e.total = row_total(g ? req1_rows : req0_rows);
        exp_q.push_back(e);
        m_last = g;
      end
      m_acc0 = e0;
      m_acc1 = e1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [W-1:0] tot;
    // Reset state
    #3;
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_rsp_src", 64'(rsp_src), 64'd0);
    check("reset_rsp_tag", 64'(rsp_tag), 64'd0);
    check("reset_rsp_sum", 64'(rsp_sum), 64'd0);
    check("reset_rsp_carry", 64'(rsp_carry), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single lane-0 transaction, rows 1..6, tag 3
    req0_rows  = {48'd6, 48'd5, 48'd4, 48'd3, 48'd2, 48'd1};
    req0_tag   = 4'd3;
    req0_valid = 1'b1;
    rsp_ready  = 1'b1;
    @(negedge clk);
    check("t1_req0_ready", 64'(req0_ready), 64'd1);
    step();
    req0_valid = 1'b0;
    @(negedge clk);
    tot = rsp_sum + rsp_carry;
    check("t1_rsp_valid", 64'(rsp_valid), 64'd1);
    check("t1_rsp_src", 64'(rsp_src), 64'd0);
    check("t1_rsp_tag", 64'(rsp_tag), 64'd3);
    check("t1_total", 64'(tot), 64'd21);

    // All-ones rows on lane 1
    step();
    req1_rows  = '1;
    req1_tag   = 4'd5;
    req1_valid = 1'b1;
    step();
    req1_valid = 1'b0;
    @(negedge clk);
    tot = rsp_sum + rsp_carry;
    check("ones_rsp_valid", 64'(rsp_valid), 64'd1);
    check("ones_total", 64'(tot), 64'h0000_FFFF_FFFF_FFFA);

    // Contention from reset: alternating sources (fixed build: lane 0 only)
    do_reset();
    req0_rows = rand_rows(); req0_tag = 4'd4; req0_valid = 1'b1;
    req1_rows = rand_rows(); req1_tag = 4'd5; req1_valid = 1'b1;
    rsp_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (k >= 1) begin
        check("rr_rsp_valid", 64'(rsp_valid), 64'd1);
        check("rr_rsp_src", 64'(rsp_src), FIXED ? 64'd0 : 64'((k - 1) % 2));
      end
    end
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Stall: lane 1 issues three with rsp_ready low
    do_reset();
    req1_rows = rand_rows(); req1_tag = 4'd10; req1_valid = 1'b1;
    @(negedge clk);
    check("stall_first_ready", 64'(req1_ready), 64'd1);
    step();
    req1_rows = rand_rows(); req1_tag = 4'd11;
    @(negedge clk);
    check("stall_second_ready", 64'(req1_ready), 64'd1);
    step();
    req1_rows = rand_rows(); req1_tag = 4'd12;
    @(negedge clk);
    check("stall_third_blocked", 64'(req1_ready), 64'd0);
    step();
    rsp_ready = 1'b1;
    @(negedge clk);
    check("stall_full_pop_blocked", 64'(req1_ready), 64'd0);
    check("stall_tag_a", 64'(rsp_tag), 64'd10);
    step();
    @(negedge clk);
    check("stall_third_accepted", 64'(req1_ready), 64'd1);
    check("stall_tag_b", 64'(rsp_tag), 64'd11);
    step();
    req1_valid = 1'b0;
    @(negedge clk);
    check("stall_tag_c", 64'(rsp_tag), 64'd12);

    // Reset with the buffer full
    do_reset();
    req0_rows = rand_rows(); req0_tag = 4'd1; req0_valid = 1'b1;
    step();
    req0_rows = rand_rows(); req0_tag = 4'd2;
    step();
    req0_rows = rand_rows(); req0_tag = 4'd7;
    req1_rows = rand_rows(); req1_tag = 4'd8; req1_valid = 1'b1;
    @(negedge clk);
    check("full_rsp_valid", 64'(rsp_valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("midrst_req0_ready", 64'(req0_ready), 64'd0);
    check("midrst_req1_ready", 64'(req1_ready), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    req1_valid = 1'b0;
    req0_tag   = 4'd9;
    rsp_ready  = 1'b1;
    step();
    req0_valid = 1'b0;
    @(negedge clk);
    check("postrst_rsp_valid", 64'(rsp_valid), 64'd1);
    check("postrst_rsp_tag", 64'(rsp_tag), 64'd9);

    // Randomized traffic
    for (int c = 0; c < 10000; c++) begin
      step();
      if (!req0_valid || m_acc0) begin
        req0_valid = ($urandom_range(3) != 0);
        req0_rows  = rand_rows();
        req0_tag   = TW'($urandom);
      end
      if (!req1_valid || m_acc1) begin
        req1_valid = ($urandom_range(3) != 0);
        req1_rows  = rand_rows();
        req1_tag   = TW'($urandom);
      end
      rsp_ready = ($urandom_range(3) != 0);
    end

    // Drain
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("drain_rsp_valid", 64'(rsp_valid), 64'd0);
    check("drain_model_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
